// File: rtl/scan_select_seq_if.sv
// Bus between a scan controller and the select sequencer.
// master drives en/mask/dwell; slave drives sel/sel_valid/frame_done/busy.
interface scan_select_seq_if #(
    parameter int DWELL_W = 8
);
    logic               en;
    logic [7:0]         mask;
    logic [DWELL_W-1:0] dwell;
    logic [2:0]         sel;
    logic               sel_valid;
    logic               frame_done;
    logic               busy;

    modport master (
        output en, mask, dwell,
        input  sel, sel_valid, frame_done, busy
    );

    modport slave (
        input  en, mask, dwell,
        output sel, sel_valid, frame_done, busy
    );
endinterface

// File: rtl/scan_select_seq.sv
// Select sequencer for a 3-to-8 decoder: steps sel over masked channels.
// Ports: clk, rst_n (async low), bus (slave: en/mask/dwell in, sel/valid/done/busy out).
module scan_select_seq #(
    parameter int DWELL_W      = 8,
    parameter int BLANK_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    scan_select_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEEK  = 2'd1,
        DWELL = 2'd2,
        BLANK = 2'd3
    } state_t;

    localparam logic [3:0] BLANK_LIM = 4'(BLANK_CYCLES);

    state_t             state_q, state_d;
    logic [3:0]         ptr_q, ptr_d;
    logic [2:0]         sel_q, sel_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [DWELL_W-1:0] dcnt_q, dcnt_d;
    logic [DWELL_W-1:0] dlim_q, dlim_d;
    logic [3:0]         bcnt_q, bcnt_d;

    logic               hit;
    logic [2:0]         hit_ch;
    logic [DWELL_W-1:0] dwell_eff;

    // Lowest enabled channel at or above ptr; descending loop keeps the lowest.
    always_comb begin
        hit    = 1'b0;
        hit_ch = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (bus.mask[i] && (4'(i) >= ptr_q)) begin
                hit    = 1'b1;
                hit_ch = 3'(i);
            end
        end
    end

    assign dwell_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        dcnt_d  = dcnt_q;
        dlim_d  = dlim_q;
        bcnt_d  = bcnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.en && (bus.mask != 8'h00)) begin
                    state_d = SEEK;
                    ptr_d   = 4'd0;
                end
            end
            SEEK: begin
                if (!bus.en || (bus.mask == 8'h00)) begin
                    state_d = IDLE;
                    ptr_d   = 4'd0;
                end else if (hit) begin
                    sel_d   = hit_ch;
                    valid_d = 1'b1;
                    dcnt_d  = DWELL_W'(1);
                    dlim_d  = dwell_eff;
                    state_d = DWELL;
                end else begin
                    // Wrap: one cycle spent here announcing the end of the pass.
                    done_d = 1'b1;
                    ptr_d  = 4'd0;
                end
            end
            DWELL: begin
                if (dcnt_q == dlim_q) begin
                    valid_d = 1'b0;
                    ptr_d   = {1'b0, sel_q} + 4'd1;
                    bcnt_d  = 4'd1;
                    state_d = (BLANK_CYCLES == 0) ? SEEK : BLANK;
                end else begin
                    dcnt_d = dcnt_q + DWELL_W'(1);
                end
            end
            BLANK: begin
                if (bcnt_q == BLANK_LIM) begin
                    state_d = SEEK;
                end else begin
                    bcnt_d = bcnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 4'd0;
            sel_q   <= 3'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            dcnt_q  <= '0;
            dlim_q  <= '0;
            bcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            dcnt_q  <= dcnt_d;
            dlim_q  <= dlim_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.sel_valid  = valid_q;
    assign bus.frame_done = done_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_scan_select_seq.sv
// Directed bench for scan_select_seq (BLANK_CYCLES=1 and BLANK_CYCLES=0 builds).
// Outputs packed as {sel[2:0], sel_valid, frame_done, busy}.
module tb_scan_select_seq;
    logic clk;
    logic rst_n;

    scan_select_seq_if #(.DWELL_W(8)) m_if ();
    scan_select_seq_if #(.DWELL_W(8)) z_if ();

    scan_select_seq #(.DWELL_W(8), .BLANK_CYCLES(1)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if)
    );

    scan_select_seq #(.DWELL_W(8), .BLANK_CYCLES(0)) u_b0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (z_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         b0;
        bit         en;
        logic [7:0] mask;
        logic [7:0] dwell;
        logic [5:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   n_pass;
    int   n_tot;

    function automatic logic [5:0] e(int s, bit v, bit fd, bit b);
        return {3'(s), v, fd, b};
    endfunction

    function automatic logic [5:0] outs(bit b0);
        if (b0)
            return {z_if.sel, z_if.sel_valid, z_if.frame_done, z_if.busy};
        return {m_if.sel, m_if.sel_valid, m_if.frame_done, m_if.busy};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_tot++;
        if (act !== req)
            $display("FAIL %s: got %b want %b", name, act, req);
        else
            n_pass++;
    endtask

    task automatic add(bit rst, bit b0, bit en, logic [7:0] mask,
                       logic [7:0] dwell, logic [5:0] exp, string name);
        vec_t v;
        v.rst = rst; v.b0 = b0; v.en = en; v.mask = mask;
        v.dwell = dwell; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic set_in(bit en, logic [7:0] mask, logic [7:0] dwell);
        m_if.en = en; m_if.mask = mask; m_if.dwell = dwell;
        z_if.en = en; z_if.mask = mask; z_if.dwell = dwell;
    endtask

    task automatic do_rst(bit b0);
        set_in(1'b0, 8'h00, 8'h00);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_state", 32'(outs(b0)), 32'(6'b0));
        rst_n = 1'b1;
    endtask

    initial begin
        int         runs;
        int         since_fd;
        int         fds;
        int         viol;
        int         run_len;
        logic [2:0] run_sel;
        logic [2:0] p_sel;
        logic       p_v;
        bit         found;

        n_pass = 0;
        n_tot  = 0;
        rst_n  = 1'b0;
        set_in(1'b0, 8'h00, 8'h00);

        // nominal: mask 05, dwell 2, blank 1
        add(1, 0, 1, 8'h05, 8'd2, e(0, 0, 0, 1), "nom_seek");
        add(0, 0, 1, 8'h05, 8'd2, e(0, 1, 0, 1), "nom_c0_a");
        add(0, 0, 1, 8'h05, 8'd2, e(0, 1, 0, 1), "nom_c0_b");
        add(0, 0, 1, 8'h05, 8'd2, e(0, 0, 0, 1), "nom_blank0");
        add(0, 0, 1, 8'h05, 8'd2, e(0, 0, 0, 1), "nom_seek1");
        add(0, 0, 1, 8'h05, 8'd2, e(2, 1, 0, 1), "nom_c2_a");
        add(0, 0, 1, 8'h05, 8'd2, e(2, 1, 0, 1), "nom_c2_b");
        add(0, 0, 1, 8'h05, 8'd2, e(2, 0, 0, 1), "nom_blank2");
        add(0, 0, 1, 8'h05, 8'd2, e(2, 0, 0, 1), "nom_seek2");
        add(0, 0, 1, 8'h05, 8'd2, e(2, 0, 1, 1), "nom_wrap");
        add(0, 0, 1, 8'h05, 8'd2, e(0, 1, 0, 1), "nom_c0_again");
        add(0, 0, 1, 8'h05, 8'd2, e(0, 1, 0, 1), "nom_c0_again_b");
        add(0, 0, 1, 8'h05, 8'd2, e(0, 0, 0, 1), "nom_blank_again");
        // stop mid-channel: mask 08, dwell 5, en drops during dwell
        add(1, 0, 1, 8'h08, 8'd5, e(0, 0, 0, 1), "stop_seek");
        add(0, 0, 1, 8'h08, 8'd5, e(3, 1, 0, 1), "stop_d1");
        add(0, 0, 0, 8'h08, 8'd5, e(3, 1, 0, 1), "stop_d2");
        add(0, 0, 0, 8'h08, 8'd5, e(3, 1, 0, 1), "stop_d3");
        add(0, 0, 0, 8'h08, 8'd5, e(3, 1, 0, 1), "stop_d4");
        add(0, 0, 0, 8'h08, 8'd5, e(3, 1, 0, 1), "stop_d5");
        add(0, 0, 0, 8'h08, 8'd5, e(3, 0, 0, 1), "stop_blank");
        add(0, 0, 0, 8'h08, 8'd5, e(3, 0, 0, 1), "stop_seek2");
        add(0, 0, 0, 8'h08, 8'd5, e(3, 0, 0, 0), "stop_idle");
        add(0, 0, 0, 8'h08, 8'd5, e(3, 0, 0, 0), "stop_idle2");
        // mask 0 stays idle, then single channel 7 repeats
        add(1, 0, 1, 8'h00, 8'd3, e(0, 0, 0, 0), "m0_idle");
        add(0, 0, 1, 8'h00, 8'd3, e(0, 0, 0, 0), "m0_idle2");
        add(0, 0, 1, 8'h80, 8'd3, e(0, 0, 0, 1), "m80_seek");
        add(0, 0, 1, 8'h80, 8'd3, e(7, 1, 0, 1), "m80_d1");
        add(0, 0, 1, 8'h80, 8'd3, e(7, 1, 0, 1), "m80_d2");
        add(0, 0, 1, 8'h80, 8'd3, e(7, 1, 0, 1), "m80_d3");
        add(0, 0, 1, 8'h80, 8'd3, e(7, 0, 0, 1), "m80_blank");
        add(0, 0, 1, 8'h80, 8'd3, e(7, 0, 0, 1), "m80_seek2");
        add(0, 0, 1, 8'h80, 8'd3, e(7, 0, 1, 1), "m80_wrap");
        add(0, 0, 1, 8'h80, 8'd3, e(7, 1, 0, 1), "m80_r2_d1");
        add(0, 0, 1, 8'h80, 8'd3, e(7, 1, 0, 1), "m80_r2_d2");
        add(0, 0, 1, 8'h80, 8'd3, e(7, 1, 0, 1), "m80_r2_d3");
        add(0, 0, 1, 8'h80, 8'd3, e(7, 0, 0, 1), "m80_r2_blank");
        add(0, 0, 1, 8'h80, 8'd3, e(7, 0, 0, 1), "m80_r2_seek");
        add(0, 0, 1, 8'h80, 8'd3, e(7, 0, 1, 1), "m80_r2_wrap");
        add(0, 0, 1, 8'h80, 8'd3, e(7, 1, 0, 1), "m80_r3_d1");
        // BLANK_CYCLES=0 build: mask 03, dwell 1
        add(1, 1, 1, 8'h03, 8'd1, e(0, 0, 0, 1), "b0_seek");
        add(0, 1, 1, 8'h03, 8'd1, e(0, 1, 0, 1), "b0_c0");
        add(0, 1, 1, 8'h03, 8'd1, e(0, 0, 0, 1), "b0_seek1");
        add(0, 1, 1, 8'h03, 8'd1, e(1, 1, 0, 1), "b0_c1");
        add(0, 1, 1, 8'h03, 8'd1, e(1, 0, 0, 1), "b0_seek2");
        add(0, 1, 1, 8'h03, 8'd1, e(1, 0, 1, 1), "b0_wrap");
        add(0, 1, 1, 8'h03, 8'd1, e(0, 1, 0, 1), "b0_c0_again");
        add(0, 1, 1, 8'h03, 8'd1, e(0, 0, 0, 1), "b0_seek3");

        foreach (vecs[k]) begin
            if (vecs[k].rst) do_rst(vecs[k].b0);
            set_in(vecs[k].en, vecs[k].mask, vecs[k].dwell);
            @(posedge clk);
            #1;
            check(vecs[k].name, 32'(outs(vecs[k].b0)), 32'(vecs[k].exp));
        end

        // full mask, zero dwell: two passes of 0..7, one cycle each
        do_rst(1'b0);
        set_in(1'b1, 8'hFF, 8'd0);
        runs = 0; since_fd = 0; fds = 0; viol = 0;
        run_len = 0; run_sel = 3'd0;
        p_sel = m_if.sel; p_v = m_if.sel_valid;
        for (int c = 0; c < 200 && fds < 2; c++) begin
            @(posedge clk);
            #1;
            if ((m_if.sel != p_sel) && !(!p_v && m_if.sel_valid))
                viol++;
            if (m_if.sel_valid && !p_v) begin
                run_len = 1;
                run_sel = m_if.sel;
            end else if (m_if.sel_valid && p_v) begin
                run_len++;
            end else if (!m_if.sel_valid && p_v) begin
                check($sformatf("full_sel_%0d", runs), 32'(run_sel), 32'(runs % 8));
                check($sformatf("full_len_%0d", runs), 32'(run_len), 32'd1);
                runs++;
                since_fd++;
            end
            if (m_if.frame_done) begin
                check($sformatf("full_fd_%0d", fds), 32'(since_fd), 32'd8);
                fds++;
                since_fd = 0;
            end
            p_sel = m_if.sel;
            p_v   = m_if.sel_valid;
        end
        check("full_frames", 32'(fds), 32'd2);
        check("full_sel_stable", 32'(viol), 32'd0);

        // async reset mid-dwell
        do_rst(1'b0);
        set_in(1'b1, 8'h0C, 8'd4);
        repeat (3) @(posedge clk);
        #1;
        check("ar_pre", 32'(outs(1'b0)), 32'(e(2, 1, 0, 1)));
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_async", 32'(outs(1'b0)), 32'(6'b0));
        #1;
        rst_n = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(posedge clk);
            #1;
            if (m_if.sel_valid) found = 1'b1;
        end
        check("ar_restart_found", 32'(found), 32'd1);
        check("ar_restart_sel", 32'(m_if.sel), 32'd2);

        set_in(1'b0, 8'h00, 8'h00);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
